ext_sram_ctrl: RTL and testbench
================================

// Module: ext_sram_ctrl
// PURPOSE
//  Parametrised controller for external byte-wide SRAM behind two '373-style address latches on the shared 8-bit uio bus.
//  Turns single-cycle byte/word requests from the core into latch, read and write strobe sequences with programmable wait states.
//  Caches the last latched address bytes so that repeated accesses skip redundant latch cycles.
//  Sits between the CPU/loader and uio_*/uo_out[7:6,2:0].
// PARAMETERS
//  ADDR_W   16  byte-address width, legal 9..17; ext addr = {lah_latch, lal_latch, bh}
//  RD_WAIT   0  extra cycles oeb held low per read byte (0..15)
//  WR_WAIT   0  extra cycles web held low per write byte (0..15)
//  LAT_CACHE 1  1 = skip lal/lah cycle when latch content unchanged; 0 = always latch both
// PORTS
//  clk      in   1       system clock
//  rst_n    in   1       async active-low reset
//  req      in   1       command strobe; sampled only in IDLE
//  we       in   1       1 = write, 0 = read
//  word     in   1       1 = 16-bit little-endian access (addr[0] forced 0), 0 = byte
//  addr     in   ADDR_W  byte address
//  wdata    in   16      write data (byte access uses [7:0])
//  rdata    out  16      read data, valid with ack; byte read = {8'h00,byte}
//  ack      out  1       one-cycle completion pulse
//  busy     out  1       high whenever state != IDLE
//  bus_dout out  8       to uio_out
//  bus_oe   out  1       drive enable for uio (uio_oe = {8{bus_oe}})
//  bus_din  in   8       from uio_in
//  lal      out  1       low address latch strobe (active high)
//  lah      out  1       high address latch strobe (active high)
//  bh       out  1       ext address bit 0
//  oeb      out  1       SRAM output enable, active low
//  web      out  1       SRAM write enable, active low
// BEHAVIOUR
//  Reset (async): state=IDLE, web=oeb=1, lal=lah=bh=0, bus_oe=0, bus_dout=0, ack=0, rdata=0, latch cache invalid.
//  All outputs are registered. States: IDLE, LATL, LATH, RD, WR, WH, DONE.
//  IDLE: on req=1, capture addr/we/word/wdata; next state = LATL, else LATH, else RD/WR (skip per cache).
//  LATL: bus_oe=1, bus_dout=A[8:1], lal=1 for 1 cycle. Skipped if LAT_CACHE && lo cache valid && equal.
//  LATH: bus_oe=1, bus_dout={(17-ADDR_W) zeros, A[ADDR_W-1:9]}, lah=1 for 1 cycle; skipped likewise.
//  RD: bus_oe=0, bh=byte index, oeb=0 for RD_WAIT+1 cycles; bus_din sampled in last cycle; oeb=1 on exit.
//  WR: bus_oe=1, bus_dout=data byte, bh=byte index, web=0 for WR_WAIT+1 cycles.
//  WH: web=1, data/bh still driven 1 cycle (hold). Then bus_oe drops.
//  Word: byte 0 (bh=0, wdata[7:0]/rdata[7:0]) then byte 1 (bh=1, [15:8]); no relatch between bytes.
//  DONE: ack=1 for 1 cycle, rdata stable until next read completes; -> IDLE.
//  Latency from req-accept cycle (cycle 0), zero waits:
//    byte read: ack at 4 with both latches, 3 with one, 2 on full cache hit.
//    byte write: ack at 5 / 4 / 3.
//    Each word access adds one RD or WR+WH slot.
//  Cache updated only when a latch cycle completes.
//  req outside IDLE (including the DONE cycle) is ignored, not queued.
//  Reset mid-access: all strobes deassert immediately, no ack, cache invalid, so the next access latches both.
//  lal, lah, oeb=0 and web=0 are mutually exclusive in every cycle.
//  bus_oe=0 whenever oeb=0.
// TESTING
//  1 Byte write 0x5A @0x4001, cold: lal with 0x00, lah with 0x20, bh=1, web low 1 cycle with bus_dout=0x5A, ack at cycle 5.
//  2 Byte read @0x4001 right after: no lal/lah, oeb low 1 cycle, rdata=0x005A, ack at cycle 2.
//  3 Word write 0xBEEF @0x4100: lal only (0x80); write 0xEF at bh=0, then 0xBE at bh=1; lah absent.
//  4 RD_WAIT=2 word read @0x4100: oeb low 3 cycles per byte, rdata=0xBEEF, ack single pulse.
//  5 rst_n low while web=0: web=1 and bus_oe=0 at once, no ack; next read latches both bytes.
//  6 req pulsed while busy -> ignored, one ack only.
//    ADDR_W=16 addr 0xFFFF byte read -> lal 0xFF, lah 0x7F, bh=1.

Source files
------------

// File: rtl/ext_sram_ctrl.sv
// ext_sram_ctrl
//   Controller for an external byte-wide SRAM that sits behind two '373-style
//   address latches on a shared 8-bit bus. It turns single-cycle byte or word
//   requests into latch, read and write strobe sequences, with programmable
//   wait states. The last latched address bytes are cached, so repeated
//   accesses skip redundant latch cycles.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req, we, word       command strobe (sampled only in IDLE), write select,
//                       16-bit access select
//   addr [ADDR_W-1:0]   byte address (addr[0] is ignored for word access)
//   wdata[15:0]         write data (a byte access uses [7:0])
//   rdata[15:0], ack    read data and its one-cycle completion pulse
//   busy                high whenever the controller is not idle
//   bus_dout, bus_oe    shared bus output and its drive enable
//   bus_din             shared bus input
//   lal, lah            low/high address latch strobes (active high)
//   bh                  external address bit 0
//   oeb, web            SRAM output/write enables (active low)
module ext_sram_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int RD_WAIT   = 0,
  parameter int WR_WAIT   = 0,
  parameter int LAT_CACHE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic              word,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              ack,
  output logic              busy,
  output logic [7:0]        bus_dout,
  output logic              bus_oe,
  input  logic [7:0]        bus_din,
  output logic              lal,
  output logic              lah,
  output logic              bh,
  output logic              oeb,
  output logic              web
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATL, S_LATH, S_RD, S_WR, S_WH, S_DONE
  } state_t;

  state_t state, state_nx, acc_st;

  logic [ADDR_W-1:0] a_q, a_cur;
  logic [15:0]       wd_q, wd_cur, a_sh;
  logic              we_q, word_q, we_cur, word_cur;
  logic [3:0]        cnt, cnt_nx;
  logic              bi, bi_nx, byte_sel;
  logic [7:0]        rlo;
  logic              lo_v, hi_v;
  logic [7:0]        lo_c, hi_c, lo_b, hi_b;
  logic              need_lo, need_hi, idle, rd_last;

  logic       lal_nx, lah_nx, oeb_nx, web_nx, oe_nx, bh_nx, ack_nx;
  logic [7:0] dout_nx;

  // Outputs are registered from the next state, so in IDLE the live request
  // inputs must be used instead of the not-yet-captured copies.
  always_comb begin
    idle     = (state == S_IDLE);
    a_cur    = idle ? {addr[ADDR_W-1:1], addr[0] & ~word} : a_q;
    wd_cur   = idle ? wdata : wd_q;
    we_cur   = idle ? we    : we_q;
    word_cur = idle ? word  : word_q;
    a_sh     = 16'(a_cur >> 1);
    lo_b     = a_sh[7:0];
    hi_b     = a_sh[15:8];
    need_lo  = !((LAT_CACHE != 0) && lo_v && (lo_c == lo_b));
    need_hi  = !((LAT_CACHE != 0) && hi_v && (hi_c == hi_b));
    acc_st   = we_cur ? S_WR : S_RD;
    rd_last  = (state == S_RD) && (cnt == 4'(RD_WAIT));

    state_nx = state;
    cnt_nx   = cnt;
    bi_nx    = bi;
    case (state)
      S_IDLE: if (req) begin
        cnt_nx = '0;
        bi_nx  = 1'b0;
        if (need_lo)      state_nx = S_LATL;
        else if (need_hi) state_nx = S_LATH;
        else              state_nx = acc_st;
      end
      S_LATL: state_nx = need_hi ? S_LATH : acc_st;
      S_LATH: state_nx = acc_st;
      S_RD: begin
        if (rd_last) begin
          cnt_nx = '0;
          if (word_q && !bi) bi_nx = 1'b1;
          else               state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_WR: begin
        if (cnt == 4'(WR_WAIT)) begin
          cnt_nx   = '0;
          state_nx = S_WH;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_WH: begin
        if (word_q && !bi) begin
          bi_nx    = 1'b1;
          state_nx = S_WR;
        end else begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    byte_sel = word_cur ? bi_nx : a_cur[0];
    lal_nx   = 1'b0;
    lah_nx   = 1'b0;
    oeb_nx   = 1'b1;
    web_nx   = 1'b1;
    oe_nx    = 1'b0;
    bh_nx    = 1'b0;
    ack_nx   = 1'b0;
    dout_nx  = '0;
    case (state_nx)
      S_LATL: begin oe_nx = 1'b1; dout_nx = lo_b; lal_nx = 1'b1; end
      S_LATH: begin oe_nx = 1'b1; dout_nx = hi_b; lah_nx = 1'b1; end
      S_RD:   begin bh_nx = byte_sel; oeb_nx = 1'b0; end
      S_WR, S_WH: begin
        oe_nx   = 1'b1;
        bh_nx   = byte_sel;
        dout_nx = (word_cur && bi_nx) ? wd_cur[15:8] : wd_cur[7:0];
        web_nx  = (state_nx != S_WR);
      end
      S_DONE:  ack_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bi       <= 1'b0;
      a_q      <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      word_q   <= 1'b0;
      rlo      <= '0;
      lo_v     <= 1'b0;
      hi_v     <= 1'b0;
      lo_c     <= '0;
      hi_c     <= '0;
      rdata    <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      bus_dout <= '0;
      bus_oe   <= 1'b0;
      lal      <= 1'b0;
      lah      <= 1'b0;
      bh       <= 1'b0;
      oeb      <= 1'b1;
      web      <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bi       <= bi_nx;
      ack      <= ack_nx;
      busy     <= (state_nx != S_IDLE);
      bus_dout <= dout_nx;
      bus_oe   <= oe_nx;
      lal      <= lal_nx;
      lah      <= lah_nx;
      bh       <= bh_nx;
      oeb      <= oeb_nx;
      web      <= web_nx;
      if (idle && req) begin
        a_q    <= a_cur;
        wd_q   <= wdata;
        we_q   <= we;
        word_q <= word;
      end
      if (state == S_LATL) begin
        lo_v <= 1'b1;
        lo_c <= lo_b;
      end
      if (state == S_LATH) begin
        hi_v <= 1'b1;
        hi_c <= hi_b;
      end
      // rdata changes only on the edge that raises ack for a read.
      if (rd_last) begin
        if (word_q && !bi) rlo   <= bus_din;
        else if (word_q)   rdata <= {bus_din, rlo};
        else               rdata <= {8'h00, bus_din};
      end
    end
  end

endmodule

// File: tb/tb_ext_sram_ctrl.sv
module tb_ext_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [2];
  logic        req    [2];
  logic        we     [2];
  logic        word   [2];
  logic [15:0] addr   [2];
  logic [15:0] wdata  [2];
  logic [7:0]  din    [2];
  logic [15:0] rdata  [2];
  logic        ack    [2];
  logic        busy   [2];
  logic [7:0]  dout   [2];
  logic        bus_oe [2];
  logic        lal    [2];
  logic        lah    [2];
  logic        bh     [2];
  logic        oeb    [2];
  logic        web    [2];

  ext_sram_ctrl #(.ADDR_W(16), .RD_WAIT(0), .WR_WAIT(0), .LAT_CACHE(1)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .word(word[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]),
    .bus_dout(dout[0]), .bus_oe(bus_oe[0]), .bus_din(din[0]), .lal(lal[0]), .lah(lah[0]),
    .bh(bh[0]), .oeb(oeb[0]), .web(web[0])
  );

  ext_sram_ctrl #(.ADDR_W(16), .RD_WAIT(2), .WR_WAIT(1), .LAT_CACHE(1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .word(word[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]),
    .bus_dout(dout[1]), .bus_oe(bus_oe[1]), .bus_din(din[1]), .lal(lal[1]), .lah(lah[1]),
    .bh(bh[1]), .oeb(oeb[1]), .web(web[1])
  );

  typedef struct {
    int          inst;
    logic        rd;
    logic [15:0] rdata;
    int          acc;
    int          lat;
  } sb_t;

  sb_t        sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         excl_bad = 0;
  int         acks    [2] = '{0, 0};
  int         lal_n   [2] = '{0, 0};
  int         lah_n   [2] = '{0, 0};
  int         oeb_low [2] = '{0, 0};
  int         web_low [2] = '{0, 0};
  logic [7:0] lal_q[$];
  logic [7:0] lah_q[$];
  logic [8:0] wr_q[$];
  logic       rdbh_q[$];
  logic [7:0] mem[int];
  logic [7:0] lat_lo [2];
  logic [7:0] lat_hi [2];

  function automatic logic [7:0] rdm(input int i, input logic [16:0] a);
    int k;
    k = i * 131072 + int'(a);
    return mem.exists(k) ? mem[k] : 8'h00;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // '373 latches and SRAM array for both controllers.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (lal[i]) lat_lo[i] <= dout[i];
      if (lah[i]) lat_hi[i] <= dout[i];
      if (!web[i]) mem[i * 131072 + int'({lat_hi[i], lat_lo[i], bh[i]})] = dout[i];
    end
  end

  // Bus monitor: strobe logs, invariants, and scoreboard pops on ack.
  always @(negedge clk) begin
    sb_t e;
    for (int i = 0; i < 2; i++) begin
      din[i] = oeb[i] ? 8'h00 : rdm(i, {lat_hi[i], lat_lo[i], bh[i]});
      if ((int'(lal[i]) + int'(lah[i]) + int'(!oeb[i]) + int'(!web[i])) > 1 ||
          (!oeb[i] && bus_oe[i]))
        excl_bad++;
      if (lal[i]) begin lal_n[i]++; if (i == 0) lal_q.push_back(dout[i]); end
      if (lah[i]) begin lah_n[i]++; if (i == 0) lah_q.push_back(dout[i]); end
      if (!web[i]) begin web_low[i]++; if (i == 0) wr_q.push_back({bh[i], dout[i]}); end
      if (!oeb[i]) begin oeb_low[i]++; if (i == 0) rdbh_q.push_back(bh[i]); end
      if (ack[i]) begin
        acks[i]++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack inst=%0d: ack seen, required no pending access", i);
        end else begin
          e = sb.pop_front();
          if (e.inst != i || (cyc - e.acc) != e.lat || (e.rd && rdata[i] !== e.rdata)) begin
            bad++;
            $display("FAIL ack_check inst=%0d: latency=%0d rdata=%h, required inst=%0d latency=%0d rdata=%h",
                     i, cyc - e.acc, rdata[i], e.inst, e.lat, e.rd ? e.rdata : rdata[i]);
          end
        end
      end
    end
  end

  task automatic clear_logs(input int i);
    lal_q.delete(); lah_q.delete(); wr_q.delete(); rdbh_q.delete();
    lal_n[i] = 0; lah_n[i] = 0; oeb_low[i] = 0; web_low[i] = 0;
  endtask

  task automatic wait_ack(input int i, input int a0);
    for (int k = 0; k < 60 && acks[i] == a0; k++) begin @(negedge clk); #1; end
    if (acks[i] == a0) begin
      total++; bad++;
      $display("FAIL ack_timeout inst=%0d: no ack within 60 cycles, required one", i);
      sb.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic access(input int i, input logic w, input logic wd, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp, input int lat);
    int a0;
    @(negedge clk); #1;
    clear_logs(i);
    a0 = acks[i];
    req[i] = 1'b1; we[i] = w; word[i] = wd; addr[i] = a; wdata[i] = d;
    sb.push_back('{i, !w, exp, cyc, lat});
    @(negedge clk); #1;
    req[i] = 1'b0;
    wait_ack(i, a0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; word[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; din[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({web[i], oeb[i], lal[i], lah[i], bh[i], bus_oe[i], ack[i], busy[i]} !== 8'b1100_0000) begin
        bad++;
        $display("FAIL reset_strobes inst=%0d: got %b, required 11000000", i,
                 {web[i], oeb[i], lal[i], lah[i], bh[i], bus_oe[i], ack[i], busy[i]});
      end
      total++;
      if ({dout[i], rdata[i]} !== 24'h0) begin
        bad++;
        $display("FAIL reset_data inst=%0d: got dout=%h rdata=%h, required 00/0000", i, dout[i], rdata[i]);
      end
      rst_n[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cold_write;
    access(0, 1'b1, 1'b0, 16'h4001, 16'h005A, 16'h0, 5);
    total++;
    if (lal_q.size() != 1 || lal_q[0] !== 8'h00 || lah_q.size() != 1 || lah_q[0] !== 8'h20) begin
      bad++;
      $display("FAIL cold_write_latch: lal count=%0d lah count=%0d, required one lal 00 and one lah 20",
               lal_q.size(), lah_q.size());
    end
    total++;
    if (wr_q.size() != 1 || wr_q[0] !== 9'h15A) begin
      bad++;
      $display("FAIL cold_write_strobe: web low cycles=%0d first=%h, required 1 cycle bh=1 data 5A",
               wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 9'h0);
    end
  endtask

  task automatic test_cached_read;
    access(0, 1'b0, 1'b0, 16'h4001, 16'h0, 16'h005A, 2);
    total++;
    if (lal_n[0] != 0 || lah_n[0] != 0 || oeb_low[0] != 1) begin
      bad++;
      $display("FAIL cached_read: lal=%0d lah=%0d oeb_low=%0d, required 0 0 1", lal_n[0], lah_n[0], oeb_low[0]);
    end
  endtask

  task automatic test_word_write;
    access(0, 1'b1, 1'b1, 16'h4100, 16'hBEEF, 16'h0, 6);
    total++;
    if (lal_q.size() != 1 || lal_q[0] !== 8'h80 || lah_n[0] != 0) begin
      bad++;
      $display("FAIL word_write_latch: lal count=%0d lah count=%0d, required one lal 80, no lah",
               lal_q.size(), lah_n[0]);
    end
    total++;
    if (wr_q.size() != 2 || wr_q[0] !== 9'h0EF || wr_q[1] !== 9'h1BE) begin
      bad++;
      $display("FAIL word_write_bytes: count=%0d, required EF at bh=0 then BE at bh=1", wr_q.size());
    end
  endtask

  task automatic test_busy_ignored;
    int a0;
    @(negedge clk); #1;
    clear_logs(0);
    a0 = acks[0];
    req[0] = 1'b1; we[0] = 1'b0; word[0] = 1'b1; addr[0] = 16'h4100;
    sb.push_back('{0, 1'b1, 16'hBEEF, cyc, 3});
    @(negedge clk); #1;                      // cycle 1: req still high while busy
    @(negedge clk); #1; req[0] = 1'b0;       // cycle 2
    @(negedge clk); #1;                      // cycle 3: DONE, new req must be ignored
    req[0] = 1'b1; addr[0] = 16'h0000; word[0] = 1'b0;
    @(negedge clk); #1; req[0] = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    total++;
    if (acks[0] - a0 != 1 || busy[0] !== 1'b0 || oeb_low[0] != 2) begin
      bad++;
      $display("FAIL busy_ignored: acks=%0d busy=%b oeb_low=%0d, required 1 0 2",
               acks[0] - a0, busy[0], oeb_low[0]);
    end
  endtask

  task automatic test_top_addr;
    access(0, 1'b0, 1'b0, 16'hFFFF, 16'h0, 16'h0000, 4);
    total++;
    if (lal_q.size() != 1 || lal_q[0] !== 8'hFF || lah_q.size() != 1 || lah_q[0] !== 8'h7F ||
        rdbh_q.size() != 1 || rdbh_q[0] !== 1'b1) begin
      bad++;
      $display("FAIL top_addr_latch: lal=%0d lah=%0d rd=%0d, required lal FF, lah 7F, one read at bh=1",
               lal_q.size(), lah_q.size(), rdbh_q.size());
    end
    access(0, 1'b1, 1'b0, 16'hFFFF, 16'h00C3, 16'h0, 3);
    access(0, 1'b0, 1'b0, 16'hFFFF, 16'h0, 16'h00C3, 2);
  endtask

  task automatic test_reset_mid;
    int a0;
    @(negedge clk); #1;
    a0 = acks[0];
    req[0] = 1'b1; we[0] = 1'b1; word[0] = 1'b0; addr[0] = 16'h0002; wdata[0] = 16'h00AA;
    @(negedge clk); #1; req[0] = 1'b0;       // cycle 1 LATL
    @(negedge clk);                          // cycle 2 LATH
    @(negedge clk); #1;                      // cycle 3 WR
    total++;
    if (web[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_pre: web=%b, required 0", web[0]);
    end
    rst_n[0] = 1'b0;
    #1;
    total++;
    if ({web[0], oeb[0], bus_oe[0], lal[0], lah[0], busy[0]} !== 6'b110000) begin
      bad++;
      $display("FAIL reset_mid_strobes: got %b, required 110000",
               {web[0], oeb[0], bus_oe[0], lal[0], lah[0], busy[0]});
    end
    repeat (3) @(negedge clk);
    #1;
    rst_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (acks[0] != a0 || rdm(0, 17'h00002) !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_noack: acks=%0d mem=%h, required %0d and 00", acks[0], rdm(0, 17'h00002), a0);
    end
    access(0, 1'b0, 1'b0, 16'hFFFF, 16'h0, 16'h00C3, 4);
    total++;
    if (lal_q.size() != 1 || lal_q[0] !== 8'hFF || lah_q.size() != 1 || lah_q[0] !== 8'h7F) begin
      bad++;
      $display("FAIL reset_mid_relatch: lal=%0d lah=%0d, required both latched (FF, 7F)",
               lal_q.size(), lah_q.size());
    end
  endtask

  task automatic test_wait_states;
    access(1, 1'b1, 1'b1, 16'h4100, 16'hBEEF, 16'h0, 9);
    total++;
    if (web_low[1] != 4 || lal_n[1] != 1 || lah_n[1] != 1) begin
      bad++;
      $display("FAIL wait_write: web_low=%0d lal=%0d lah=%0d, required 4 1 1", web_low[1], lal_n[1], lah_n[1]);
    end
    access(1, 1'b0, 1'b1, 16'h4100, 16'h0, 16'hBEEF, 7);
    total++;
    if (oeb_low[1] != 6 || lal_n[1] != 0 || lah_n[1] != 0) begin
      bad++;
      $display("FAIL wait_read: oeb_low=%0d lal=%0d lah=%0d, required 6 0 0", oeb_low[1], lal_n[1], lah_n[1]);
    end
  endtask

  initial begin
    test_reset();
    test_cold_write();
    test_cached_read();
    test_word_write();
    test_busy_ignored();
    test_top_addr();
    test_reset_mid();
    test_wait_states();
    total++;
    if (excl_bad != 0 || sb.size() != 0) begin
      bad++;
      $display("FAIL invariants: strobe conflicts=%0d pending=%0d, required 0 0", excl_bad, sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
